fpu_normalize_round: RTL and testbench
======================================

// Module: fpu_normalize_round
// PURPOSE
//  Post-multiply stage of the FPU datapath: consumes the raw sign, exponent and
//  unnormalized product mantissa from the iterative multiplier. Normalizes one
//  bit per cycle, then rounds, packs and emits an IEEE-754 word with status flags.
//  Iterative design: start/busy/done handshake, one operation in flight.
// PARAMETERS
//  E       8   exponent width (biased, bias = 2**(E-1)-1)
//  F       23  stored fraction width (hidden bit excluded)
//  OFFSET  3   extra low-order product bits (guard + sticky source); must be >= 2
//  W = F+OFFSET+1 (local) mantissa input width; bits [W-1:W-2] are integer bits
// PORTS
//  clk       in   1      clock
//  rst       in   1      synchronous, active-high reset
//  start     in   1      launch; sampled only in IDLE
//  in_s      in   1      product sign
//  in_e      in   E+2    biased exponent, two's complement (upstream sign-extends)
//  in_f      in   W      mantissa, value in [0,4): 2 integer bits, W-2 fraction bits
//  busy      out  1      high from cycle after start through ROUND state
//  done      out  1      one-cycle pulse; result/flags valid this cycle and held
//  result    out  1+E+F  packed {sign, exponent, fraction}
//  ovf       out  1      result overflowed to infinity
//  unf       out  1      result underflowed, flushed to signed zero
//  inexact   out  1      discarded bits nonzero (guard|sticky)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, ovf=0, unf=0, inexact=0.
//  rst wins over everything, including mid-operation; partial work is dropped.
//  FSM: IDLE -> NORM -> ROUND -> DONE -> IDLE.
//   IDLE : on start, capture in_s/in_e/in_f into internal regs, go NORM; else hold.
//          Outputs of previous op held until next done.
//   NORM : one step per cycle, priority order:
//          mant==0              -> go ROUND (zero path)
//          mant[W-1]==1         -> mant>>=1, sticky|=mant[0], exp+=1, go ROUND
//          mant[W-2]==1         -> go ROUND (already normalized)
//          else                 -> mant<<=1, exp-=1, stay NORM
//          Sticky bit = OR of all bits shifted out on the right plus mant[OFFSET-3:0].
//   ROUND: hidden = mant[W-2]; frac = mant[W-3:OFFSET-1]; guard = mant[OFFSET-2].
//          Apply rounding (see CONFIGURATION); carry out of frac -> frac=0, exp+=1.
//          Then classify on final exp (signed, E+2 bits):
//            mant==0                -> result {s,0,0}, flags 0
//            exp >= 2**E-1          -> result {s,all-1s,0}, ovf=1, inexact=1
//            exp <= 0               -> result {s,0,0}, unf=1, inexact=1 (no denormals)
//            else                   -> result {s,exp[E-1:0],frac}
//          go DONE.
//   DONE : done=1 for exactly this cycle, busy=0; go IDLE. start here is ignored.
//  busy=1 in NORM and ROUND only. start while busy is ignored (no queueing).
//  Latency: done rises 3 + L cycles after the start edge, L = shift count in NORM
//   (left shifts; a right shift costs 0 extra). Worst case L = W-2.
//  Left shifts also stop if exp reaches 0 (go ROUND -> unf); avoids wasted cycles.
// CONFIGURATION
//  FPU_RNE_EN defined  : round-to-nearest-even: increment frac when
//                        guard & (sticky | frac[0]); inexact = guard|sticky.
//  FPU_RNE_EN undefined: truncate (round toward zero); frac unchanged,
//                        inexact still reported; no carry path exists.
// TESTING (F=23, E=8, OFFSET=3, W=27; in_f shown as integer bits _ fraction)
//  1.0: in_s=0,in_e=127,in_f=01_0...0, start -> result=0x3F800000, done at start+3
//  2.25: in_e=127,in_f=10_010...0 -> one right shift, result=0x40100000, done start+3
//  Left normalize: in_e=130,in_f=00_0010...0 -> 3 shifts, result=0x3F800000, start+6
//  Zero: in_s=1,in_f=0 -> result=0x80000000, ovf=unf=inexact=0
//  Overflow: in_e=254,in_f=10_0...0 -> result=0x7F800000, ovf=1; underflow:
//   in_e=0,in_f=01_0...0 -> result=0x00000000, unf=1
//  Rounding: in_e=127,in_f=01_1...1 (all ones) -> FPU_RNE_EN: 0x40000000;
//   without: 0x3FFFFFFF; inexact=1 both. Reset asserted in NORM -> IDLE, done never pulses.

Source files
------------

// File: rtl/fpu_normalize_round.sv
// ---------------------------------------------------------------------------
// fpu_normalize_round
//
// Post-multiply stage of the FPU datapath. Takes the raw sign, biased exponent
// and unnormalized product mantissa from the iterative multiplier. It then
// normalizes the mantissa one bit per cycle, rounds it, packs an IEEE-754 word
// and raises the status flags. Only one operation is in flight at a time, and
// the interface is a start/busy/done handshake.
//
// Optional feature macro:
//   FPU_RNE_EN  defined   -> round to nearest, ties to even
//               undefined -> truncate (round toward zero); no carry path
//
// Ports:
//   clk      in   1      clock
//   rst      in   1      synchronous, active-high reset
//   start    in   1      launch an operation (accepted only when idle)
//   in_s     in   1      product sign
//   in_e     in   E+2    biased exponent, two's complement
//   in_f     in   W      mantissa in [0,4): 2 integer bits, W-2 fraction bits
//   busy     out  1      operation in progress (normalize and round phases)
//   done     out  1      one-cycle pulse; result and flags are valid and held
//   result   out  1+E+F  packed {sign, exponent, fraction}
//   ovf      out  1      overflowed to infinity
//   unf      out  1      underflowed and flushed to signed zero
//   inexact  out  1      discarded bits were nonzero
//
// Timing: start is sampled at clock edge 0. done is high during the cycle that
// follows clock edge 3+L, where L is the number of left shifts. A start that
// arrives while busy, or during the done pulse, is ignored.
// ---------------------------------------------------------------------------
module fpu_normalize_round #(
    parameter int E      = 8,
    parameter int F      = 23,
    parameter int OFFSET = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_s,
    input  logic [E+1:0]     in_e,
    input  logic [F+OFFSET:0] in_f,
    output logic             busy,
    output logic             done,
    output logic [E+F:0]     result,
    output logic             ovf,
    output logic             unf,
    output logic             inexact
);

    localparam int W  = F + OFFSET + 1;
    // One bit wider than the input exponent so that a right-shift increment
    // plus a rounding carry can never wrap the sign.
    localparam int XW = E + 3;

    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((2**E) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_reg;
    logic                 s_reg;
    logic signed [XW-1:0] exp_reg;
    logic [W-1:0]         mant_reg;
    logic                 sticky_reg;

    logic                 busy_reg;
    logic                 done_reg;
    logic [E+F:0]         result_reg;
    logic                 ovf_reg;
    logic                 unf_reg;
    logic                 inexact_reg;

    // The rounded word is latched in ROUND. It is then published in DONE, so
    // the outputs of the previous operation stay stable until the new pulse.
    logic [E+F:0]         pend_result_reg;
    logic                 pend_ovf_reg;
    logic                 pend_unf_reg;
    logic                 pend_inexact_reg;

    logic [E+F:0]         result_next;
    logic                 ovf_next;
    logic                 unf_next;
    logic                 inexact_next;

    logic [F-1:0]         frac;
    logic [F-1:0]         frac_rnd;
    logic signed [XW-1:0] exp_rnd;
    logic                 guard;
    logic                 sticky_all;
    logic                 lost;
    logic                 low_sticky;

    // Bits below the guard position feed the sticky bit. With OFFSET == 2
    // there are no such bits.
    generate
        if (OFFSET > 2) begin : g_low_sticky
            assign low_sticky = |mant_reg[OFFSET-3:0];
        end else begin : g_no_low_sticky
            assign low_sticky = 1'b0;
        end
    endgenerate

`ifdef FPU_RNE_EN
    logic                 round_up;
    logic [F:0]           frac_sum;
`endif

    // Rounding and classification of the normalized mantissa.
    always_comb begin
        frac       = mant_reg[W-3:OFFSET-1];
        guard      = mant_reg[OFFSET-2];
        sticky_all = sticky_reg | low_sticky;
        lost       = guard | sticky_all;

`ifdef FPU_RNE_EN
        round_up = guard & (sticky_all | frac[0]);
        frac_sum = {1'b0, frac} + {{F{1'b0}}, round_up};
        frac_rnd = frac_sum[F-1:0];
        // A carry out of the fraction wraps it to zero and bumps the exponent.
        exp_rnd  = frac_sum[F] ? (exp_reg + EXP_ONE) : exp_reg;
`else
        frac_rnd = frac;
        exp_rnd  = exp_reg;
`endif

        result_next  = {s_reg, {E{1'b0}}, {F{1'b0}}};
        ovf_next     = 1'b0;
        unf_next     = 1'b0;
        inexact_next = 1'b0;

        if (mant_reg != '0) begin
            if (exp_rnd >= EXP_MAX) begin
                result_next  = {s_reg, {E{1'b1}}, {F{1'b0}}};
                ovf_next     = 1'b1;
                inexact_next = 1'b1;
            end else if (exp_rnd <= EXP_ZERO) begin
                // No denormal support: flush to signed zero.
                unf_next     = 1'b1;
                inexact_next = 1'b1;
            end else begin
                result_next  = {s_reg, exp_rnd[E-1:0], frac_rnd};
                inexact_next = lost;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            s_reg            <= 1'b0;
            exp_reg          <= '0;
            mant_reg         <= '0;
            sticky_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            result_reg       <= '0;
            ovf_reg          <= 1'b0;
            unf_reg          <= 1'b0;
            inexact_reg      <= 1'b0;
            pend_result_reg  <= '0;
            pend_ovf_reg     <= 1'b0;
            pend_unf_reg     <= 1'b0;
            pend_inexact_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // The done cycle belongs to the finishing operation, so a
                    // start during that cycle is not accepted.
                    if (start && !done_reg) begin
                        s_reg      <= in_s;
                        exp_reg    <= {in_e[E+1], in_e};
                        mant_reg   <= in_f;
                        sticky_reg <= 1'b0;
                        busy_reg   <= 1'b1;
                        state_reg  <= NORM;
                    end
                end
                NORM: begin
                    if (mant_reg == '0) begin
                        state_reg <= ROUND;
                    end else if (mant_reg[W-1]) begin
                        mant_reg   <= mant_reg >> 1;
                        sticky_reg <= sticky_reg | mant_reg[0];
                        exp_reg    <= exp_reg + EXP_ONE;
                        state_reg  <= ROUND;
                    end else if (mant_reg[W-2]) begin
                        state_reg <= ROUND;
                    end else if (exp_reg <= EXP_ZERO) begin
                        // The result is going to underflow anyway, so there
                        // is no point in shifting further.
                        state_reg <= ROUND;
                    end else begin
                        mant_reg <= mant_reg << 1;
                        exp_reg  <= exp_reg - EXP_ONE;
                    end
                end
                ROUND: begin
                    pend_result_reg  <= result_next;
                    pend_ovf_reg     <= ovf_next;
                    pend_unf_reg     <= unf_next;
                    pend_inexact_reg <= inexact_next;
                    busy_reg         <= 1'b0;
                    state_reg        <= DONE;
                end
                DONE: begin
                    result_reg  <= pend_result_reg;
                    ovf_reg     <= pend_ovf_reg;
                    unf_reg     <= pend_unf_reg;
                    inexact_reg <= pend_inexact_reg;
                    done_reg    <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign result  = result_reg;
    assign ovf     = ovf_reg;
    assign unf     = unf_reg;
    assign inexact = inexact_reg;

endmodule

// File: tb/tb_fpu_normalize_round.sv
// ---------------------------------------------------------------------------
// tb_fpu_normalize_round
// Scoreboard bench for fpu_normalize_round with E=8, F=23, OFFSET=3 and W=27.
// The expected word, flags and done latency are pushed when an operation is
// launched. They are popped and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_fpu_normalize_round;

    localparam int E = 8;
    localparam int F = 23;
    localparam int OFFSET = 3;
    localparam int W = F + OFFSET + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_s;
    logic [E+1:0]  in_e;
    logic [W-1:0]  in_f;
    logic          busy;
    logic          done;
    logic [E+F:0]  result;
    logic          ovf;
    logic          unf;
    logic          inexact;

    always #5 clk = ~clk;

    fpu_normalize_round #(.E(E), .F(F), .OFFSET(OFFSET)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_s    (in_s),
        .in_e    (in_e),
        .in_f    (in_f),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .unf     (unf),
        .inexact (inexact)
    );

    typedef struct {
        logic [31:0] result;
        logic        ovf;
        logic        unf;
        logic        inexact;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [31:0] r, input logic o, input logic u,
                                input logic x, input int lat);
        exp_t v;
        v.result = r; v.ovf = o; v.unf = u; v.inexact = x; v.lat = lat;
        return v;
    endfunction

    // Reference model: finds the leading one and applies the whole shift at once.
    function automatic exp_t model(input logic s, input logic [9:0] e, input logic [26:0] f);
        exp_t        v;
        int          ex;
        int          msb;
        int          need;
        int          sh;
        logic [26:0] m;
        logic [22:0] fr;
        logic        g;
        logic        st;
        ex = $signed(e);
        msb = -1;
        for (int i = 0; i < 27; i++) if (f[i]) msb = i;
        sh = 0;
        st = 1'b0;
        m = f;
        if (msb < 0) return mk({s, 31'b0}, 1'b0, 1'b0, 1'b0, 3);
        if (msb == 26) begin
            st = m[0];
            m = m >> 1;
            ex = ex + 1;
        end else begin
            need = 25 - msb;
            if (ex <= 0) sh = 0;
            else if (ex < need) sh = ex;
            else sh = need;
            m = m << sh;
            ex = ex - sh;
        end
        fr = m[24:2];
        g = m[1];
        st = st | m[0];
`ifdef FPU_RNE_EN
        if (g && (st || fr[0])) begin
            if (fr == 23'h7FFFFF) begin
                fr = '0;
                ex = ex + 1;
            end else begin
                fr = fr + 23'd1;
            end
        end
`endif
        if (ex >= 255) v = mk({s, 8'hFF, 23'h0}, 1'b1, 1'b0, 1'b1, sh + 3);
        else if (ex <= 0) v = mk({s, 31'b0}, 1'b0, 1'b1, 1'b1, sh + 3);
        else v = mk({s, 8'(ex), fr}, 1'b0, 1'b0, g | st, sh + 3);
        return v;
    endfunction

    // Launches one operation and scores it when done pulses. When hold is set,
    // start stays high with scrambled inputs until done, and none of it may be
    // accepted.
    task automatic run_op(input string name, input logic s, input logic [9:0] e,
                          input logic [26:0] f, input exp_t x, input bit hold);
        exp_t ev;
        int   cyc;
        sb.push_back(x);
        @(posedge clk); #1;
        start = 1'b1; in_s = s; in_e = e; in_f = f;
        @(posedge clk); #1;
        if (hold) begin
            in_s = ~s; in_e = e + 10'd3; in_f = ~f;
        end else begin
            start = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy: got %b want 1", name, busy);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done not seen within %0d cycles", name, cyc);
            void'(sb.pop_front());
            return;
        end
        ev = sb.pop_front();
        $display("op %-10s s=%0b e=%0d f=%07h -> result=%08h ovf=%0b unf=%0b inexact=%0b lat=%0d",
                 name, s, $signed(e), f, result, ovf, unf, inexact, cyc);
        if (result !== ev.result) begin
            errors++;
            $display("FAIL %s result: got %08h want %08h", name, result, ev.result);
        end
        checks++;
        if (ovf !== ev.ovf) begin
            errors++;
            $display("FAIL %s ovf: got %b want %b", name, ovf, ev.ovf);
        end
        checks++;
        if (unf !== ev.unf) begin
            errors++;
            $display("FAIL %s unf: got %b want %b", name, unf, ev.unf);
        end
        checks++;
        if (inexact !== ev.inexact) begin
            errors++;
            $display("FAIL %s inexact: got %b want %b", name, inexact, ev.inexact);
        end
        checks++;
        if (cyc != ev.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, ev.lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy at done: got %b want 0", name, busy);
        end
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s relaunch: busy=%b done=%b want 0 0", name, busy, done);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_s = 1'b0; in_e = '0; in_f = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, ovf, unf, inexact} !== 5'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b result=%08h ovf=%b unf=%b inexact=%b want all 0",
                     busy, done, result, ovf, unf, inexact);
        end
        $display("reset checked busy=%b done=%b result=%08h", busy, done, result);
        rst = 1'b0;
    endtask

    task automatic test_spec_vectors();
        run_op("one",      1'b0, 10'd127, 27'h2000000, mk(32'h3F800000, 0, 0, 0, 3), 1'b0);
        run_op("rshift",   1'b0, 10'd127, 27'h4800000, mk(32'h40100000, 0, 0, 0, 3), 1'b0);
        run_op("lshift3",  1'b0, 10'd130, 27'h0400000, mk(32'h3F800000, 0, 0, 0, 6), 1'b0);
        run_op("zero",     1'b1, 10'd127, 27'h0000000, mk(32'h80000000, 0, 0, 0, 3), 1'b0);
        run_op("overflow", 1'b0, 10'd254, 27'h4000000, mk(32'h7F800000, 1, 0, 1, 3), 1'b0);
        run_op("underflow",1'b0, 10'd0,   27'h2000000, mk(32'h00000000, 0, 1, 1, 3), 1'b0);
`ifdef FPU_RNE_EN
        run_op("round",    1'b0, 10'd127, 27'h3FFFFFF, mk(32'h40000000, 0, 0, 1, 3), 1'b0);
`else
        run_op("round",    1'b0, 10'd127, 27'h3FFFFFF, mk(32'h3FFFFFFF, 0, 0, 1, 3), 1'b0);
`endif
        // Left shifting stops once the exponent reaches zero: 2 shifts, then flush.
        run_op("lstop",    1'b1, 10'd2,   27'h0000010, mk(32'h80000000, 0, 1, 1, 5), 1'b0);
    endtask

    task automatic test_random();
        logic        s;
        logic [9:0]  e;
        logic [26:0] f;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            e = 10'($urandom_range(0, 290) - 12);
            f = 27'($urandom) >> $urandom_range(0, 26);
            if (i % 5 == 0) f[26] = 1'b1;
            run_op("random", s, e, f, model(s, e, f), 1'b0);
        end
    endtask

    task automatic test_busy_ignore();
        run_op("hold",  1'b0, 10'd140, 27'h0001234, model(1'b0, 10'd140, 27'h0001234), 1'b1);
        run_op("hold2", 1'b1, 10'd100, 27'h5555555, model(1'b1, 10'd100, 27'h5555555), 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_op("b2b", 1'(i), 10'(120 + i), 27'h1ABCDEF >> i,
                   model(1'(i), 10'(120 + i), 27'h1ABCDEF >> i), 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(posedge clk); #1;
        start = 1'b1; in_s = 1'b0; in_e = 10'd200; in_f = 27'h0000001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset busy before: got %b want 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset activity: busy or done seen after reset");
        end
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL midreset result: got %08h want 00000000", result);
        end
        $display("midreset busy=%b done=%b result=%08h", busy, done, result);
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
